// File: rtl/serial_word_receiver_pkg.sv
// rtl/serial_word_receiver_pkg.sv - shared types and constants for the serial word receiver
package serial_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // data_xor is the XOR-reduction of the received data bits
  function automatic logic parity_mismatch(input logic data_xor,
                                           input logic par_bit,
                                           input logic odd);
    return (data_xor ^ par_bit) != odd;
  endfunction

endpackage

// File: rtl/serial_word_receiver_if.sv
// rtl/serial_word_receiver_if.sv - valid/ready parallel word port of the receiver
interface serial_word_receiver_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;

  modport master (
    output data_out,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/serial_word_receiver_rx_shift_core.sv
// rtl/serial_word_receiver_rx_shift_core.sv - direction-selectable shift register and bit counter
module rx_shift_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             lsb_first,
  input  logic             bit_in,
  output logic [WIDTH-1:0] sh,
  output logic             last_bit
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sh  <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (shift_en) begin
      if (lsb_first) begin
        sh <= {bit_in, sh[WIDTH-1:1]};
      end else begin
        sh <= {sh[WIDTH-2:0], bit_in};
      end
      // saturate rather than wrap; the FSM leaves DATA on the last bit anyway
      if (cnt != CW'(WIDTH)) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign last_bit = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_word_receiver.sv
// rtl/serial_word_receiver.sv - start/data/parity/stop framing FSM with a one-word output buffer
module serial_word_receiver
  import serial_rx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bit_en,
  input  logic                          ser_in,
  input  logic                          lsb_first,
  input  logic                          par_en,
  input  logic                          par_odd,
  serial_word_receiver_if.master        out_if,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  rx_state_e        state, state_nxt;

  logic             lsb_q, par_en_q, par_odd_q, par_bad_q;
  logic             cfg_load, par_chk, core_shift;
  logic             stop_ok, stop_bad;
  logic             last_bit;
  logic [WIDTH-1:0] sh;

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             buf_free;

  rx_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .clear     (cfg_load),
    .shift_en  (core_shift),
    .lsb_first (lsb_q),
    .bit_in    (ser_in),
    .sh        (sh),
    .last_bit  (last_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cfg_load   = 1'b0;
    core_shift = 1'b0;
    par_chk    = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    if (bit_en) begin
      case (state)
        IDLE: begin
          if (!ser_in) begin
            state_nxt = DATA;
            cfg_load  = 1'b1;
          end
        end
        DATA: begin
          core_shift = 1'b1;
          if (last_bit) begin
            state_nxt = par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_chk   = 1'b1;
          state_nxt = STOP;
        end
        STOP: begin
          stop_ok   = ser_in;
          stop_bad  = !ser_in;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // frame configuration is captured at the start bit and frozen until IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      lsb_q     <= 1'b0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_bad_q <= 1'b0;
    end else if (cfg_load) begin
      lsb_q     <= lsb_first;
      par_en_q  <= par_en;
      par_odd_q <= par_odd;
      par_bad_q <= 1'b0;
    end else if (par_chk) begin
      par_bad_q <= parity_mismatch(^sh, ser_in, par_odd_q);
    end
  end

  assign buf_free = !valid_q || out_if.data_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= stop_bad;
      parity_err <= stop_ok && par_bad_q;
      overrun    <= stop_ok && !buf_free;
      if (stop_ok && buf_free) begin
        data_q  <= sh;
        valid_q <= 1'b1;
      end else if (valid_q && out_if.data_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_if.data_out   = data_q;
  assign out_if.data_valid = valid_q;
  assign busy              = (state != IDLE);

endmodule
